// File: rtl/alu_sequencer.sv
// alu_sequencer: single-request 8-bit ALU sequencer with ready/valid handshakes.
//
// Each request is accepted in IDLE, spends EXEC_CYCLES edges in EXEC and is then
// presented in DONE until the consumer takes it. Only one operation is in flight
// at a time.
//
// Parameters:
//   EXEC_CYCLES  1..15, number of edges spent in EXEC before the result is shown
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  high only in IDLE
//   op[2:0]    in   000 add, 001 sub, 010 mul, 011 div, 100 eq, 101 gt, 110 lt, 111 reserved
//   a[7:0]     in   operand A
//   b[7:0]     in   operand B
//   out_valid  out  high only in DONE
//   out_ready  in   consumer takes the result
//   result     out  16-bit result, held through DONE
//   flag       out  compare outcome (compare ops only)
//   err        out  divide-by-zero or reserved op
//   op_count   out  completed-operation counter, wraps 255->0
//   acc_sel    in   (ACC_CHAIN_EN only) use the accumulator as operand A
//
// Build option: define ACC_CHAIN_EN to add the acc_sel port and an 8-bit
// accumulator that captures result[7:0] of every delivered operation.
module alu_sequencer #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        flag,
    output logic        err,
    output logic [7:0]  op_count
`ifdef ACC_CHAIN_EN
    ,
    input  logic        acc_sel
`endif
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EXEC = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    // The counter counts down to zero; the zero cycle is the final EXEC edge.
    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] result_q, result_d;
    logic        flag_q, flag_d;
    logic        err_q, err_d;
    logic [7:0]  op_count_q, op_count_d;
`ifdef ACC_CHAIN_EN
    logic [7:0]  acc_q, acc_d;
`endif

    // Returns {err, flag, result} for one operation on latched operands.
    function automatic logic [17:0] alu_eval(input logic [2:0] op_i,
                                             input logic [7:0] x,
                                             input logic [7:0] y);
        logic [15:0] r;
        logic [7:0]  lo;
        logic        f;
        logic        e;
        r  = 16'h0000;
        lo = 8'h00;
        f  = 1'b0;
        e  = 1'b0;
        case (op_i)
            3'b000: begin
                lo = x + y;
                r  = {8'h00, lo};
            end
            3'b001: begin
                lo = x - y;
                r  = {8'h00, lo};
            end
            3'b010: r = {8'h00, x} * {8'h00, y};
            3'b011: begin
                if (y == 8'h00) begin
                    e = 1'b1;
                end else begin
                    r = {x % y, x / y};
                end
            end
            3'b100: f = (x == y);
            3'b101: f = (x > y);
            3'b110: f = (x < y);
            default: e = 1'b1;
        endcase
        return {e, f, r};
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        flag_d     = flag_q;
        err_d      = err_q;
        op_count_d = op_count_q;
`ifdef ACC_CHAIN_EN
        acc_d      = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_EXEC;
                    cnt_d   = CNT_LOAD;
                    op_d    = op;
                    b_d     = b;
`ifdef ACC_CHAIN_EN
                    a_d     = acc_sel ? acc_q : a;
`else
                    a_d     = a;
`endif
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    {err_d, flag_d, result_d} = alu_eval(op_q, a_q, b_q);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d    = S_IDLE;
                    op_count_d = op_count_q + 8'd1;
`ifdef ACC_CHAIN_EN
                    acc_d      = result_q[7:0];
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            op_q       <= 3'd0;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            result_q   <= 16'h0000;
            flag_q     <= 1'b0;
            err_q      <= 1'b0;
            op_count_q <= 8'h00;
`ifdef ACC_CHAIN_EN
            acc_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            flag_q     <= flag_d;
            err_q      <= err_d;
            op_count_q <= op_count_d;
`ifdef ACC_CHAIN_EN
            acc_q      <= acc_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign flag      = flag_q;
    assign err       = err_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: two instances (EXEC_CYCLES = 1 and 4) share the
// same stimulus; a transaction-level reference model per instance predicts
// handshake timing, results and the operation counter every cycle.
module tb_alu_sequencer;

`ifdef ACC_CHAIN_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic       acc_sel;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;

    logic        in_ready  [2];
    logic        out_valid [2];
    logic        flag      [2];
    logic        err       [2];
    logic [15:0] result    [2];
    logic [7:0]  op_count  [2];

    int n_cmp = 0;
    int n_bad = 0;

    alu_sequencer #(.EXEC_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .op(op), .a(a), .b(b), .out_valid(out_valid[0]), .out_ready(out_ready),
        .result(result[0]), .flag(flag[0]), .err(err[0]), .op_count(op_count[0])
`ifdef ACC_CHAIN_EN
        , .acc_sel(acc_sel)
`endif
    );

    alu_sequencer #(.EXEC_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .op(op), .a(a), .b(b), .out_valid(out_valid[1]), .out_ready(out_ready),
        .result(result[1]), .flag(flag[1]), .err(err[1]), .op_count(op_count[1])
`ifdef ACC_CHAIN_EN
        , .acc_sel(acc_sel)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference arithmetic straight from the operation table, in plain integers.
    function automatic logic [17:0] ref_eval(input int o, input int x, input int y);
        int r;
        bit f;
        bit e;
        r = 0;
        f = 0;
        e = 0;
        case (o)
            0: r = (x + y) % 256;
            1: r = (x - y + 256) % 256;
            2: r = x * y;
            3: if (y == 0) e = 1; else r = (x % y) * 256 + (x / y);
            4: f = (x == y);
            5: f = (x > y);
            6: f = (x < y);
            default: e = 1;
        endcase
        return {e, f, 16'(r)};
    endfunction

    // Transaction model: busy flag, edges left until the result shows, pending
    // and presented results, completed count, accumulator.
    int          lat    [2] = '{1, 4};
    bit          m_busy [2];
    int          m_wait [2];
    logic [17:0] p_ev   [2];
    logic [17:0] m_ev   [2];
    logic [7:0]  m_cnt  [2];
    logic [7:0]  m_acc  [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_busy[k] <= 1'b0;
                m_wait[k] <= 0;
                p_ev[k]   <= '0;
                m_ev[k]   <= '0;
                m_cnt[k]  <= '0;
                m_acc[k]  <= '0;
            end else if (!m_busy[k]) begin
                if (in_valid) begin
                    m_busy[k] <= 1'b1;
                    m_wait[k] <= lat[k];
                    p_ev[k]   <= ref_eval(int'(op), (ACC && acc_sel) ? int'(m_acc[k]) : int'(a), int'(b));
                end
            end else if (m_wait[k] > 0) begin
                m_wait[k] <= m_wait[k] - 1;
                if (m_wait[k] == 1) m_ev[k] <= p_ev[k];
            end else if (out_ready) begin
                m_busy[k] <= 1'b0;
                m_cnt[k]  <= m_cnt[k] + 8'd1;
                m_acc[k]  <= m_ev[k][7:0];
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("cyc in_ready[%0d]", k), in_ready[k], !m_busy[k]);
                chk($sformatf("cyc out_valid[%0d]", k), out_valid[k], m_busy[k] && m_wait[k] == 0);
                chk($sformatf("cyc op_count[%0d]", k), op_count[k], m_cnt[k]);
                if (m_busy[k] && m_wait[k] == 0) begin
                    chk($sformatf("cyc result[%0d]", k), result[k], m_ev[k][15:0]);
                    chk($sformatf("cyc flag[%0d]", k), flag[k], m_ev[k][16]);
                    chk($sformatf("cyc err[%0d]", k), err[k], m_ev[k][17]);
                end
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!(in_ready[0] && in_ready[1]) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("wait_idle timeout", 0, 1);
    endtask

    // One request with out_ready held high; returns EXEC_CYCLES=1 outcome and
    // the edge counts from acceptance to out_valid for both instances.
    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic sel, output logic [17:0] ev1, output int l1, output int l4);
        bit got1;
        bit got4;
        got1 = 0;
        got4 = 0;
        l1   = -1;
        l4   = -1;
        ev1  = '0;
        wait_idle();
        op = o; a = x; b = y; acc_sel = sel; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom); a = 8'($urandom); b = 8'($urandom); acc_sel = 1'($urandom);
        for (int t = 1; t <= 20 && !(got1 && got4); t++) begin
            @(posedge clk);
            #1;
            if (!got1 && out_valid[0]) begin
                got1 = 1; l1 = t; ev1 = {err[0], flag[0], result[0]};
            end
            if (!got4 && out_valid[1]) begin
                got4 = 1; l4 = t;
            end
        end
        if (!(got1 && got4)) chk("run_op timeout", 0, 1);
    endtask

    logic [17:0] ev;
    int          l1;
    int          l4;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; acc_sel = 1'b0;
        op = 3'd0; a = 8'd0; b = 8'd0;
        #3;
        for (int k = 0; k < 2; k++) begin
            chk("reset in_ready", in_ready[k], 1);
            chk("reset out_valid", out_valid[k], 0);
            chk("reset result", result[k], 0);
            chk("reset flag", flag[k], 0);
            chk("reset err", err[k], 0);
            chk("reset op_count", op_count[k], 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(3'b000, 8'd200, 8'd100, 1'b0, ev, l1, l4);
        chk("add result", ev[15:0], 16'h002C);
        chk("add err", ev[17], 0);
        chk("add latency x1", l1, 1);
        chk("add latency x4", l4, 4);
        chk("add op_count", op_count[0], 1);

        run_op(3'b010, 8'hFF, 8'hFF, 1'b0, ev, l1, l4);
        chk("mul result", ev[15:0], 16'hFE01);
        run_op(3'b011, 8'd17, 8'd5, 1'b0, ev, l1, l4);
        chk("div result", ev[15:0], 16'h0203);
        chk("div err", ev[17], 0);
        run_op(3'b011, 8'd9, 8'd0, 1'b0, ev, l1, l4);
        chk("div0 result", ev[15:0], 16'h0000);
        chk("div0 err", ev[17], 1);
        run_op(3'b001, 8'd5, 8'd7, 1'b0, ev, l1, l4);
        chk("sub wrap", ev[15:0], 16'h00FE);
        run_op(3'b101, 8'd3, 8'd3, 1'b0, ev, l1, l4);
        chk("gt flag", ev[16], 0);
        run_op(3'b110, 8'd2, 8'd3, 1'b0, ev, l1, l4);
        chk("lt flag", ev[16], 1);
        chk("lt result", ev[15:0], 16'h0000);
        run_op(3'b111, 8'd4, 8'd4, 1'b0, ev, l1, l4);
        chk("rsv err", ev[17], 1);
        chk("rsv flag", ev[16], 0);

        // Consumer stalls while new requests keep arriving.
        wait_idle();
        op = 3'b000; a = 8'd1; b = 8'd1; in_valid = 1'b1; out_ready = 1'b0; acc_sel = 1'b0;
        @(posedge clk);
        #1;
        a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            a = 8'($urandom); b = 8'($urandom);
            chk("stall out_valid", out_valid[0], 1);
            chk("stall result", result[0], 16'h0002);
            chk("stall in_ready", in_ready[0], 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;

        // Reset while the slow instance is in EXEC.
        wait_idle();
        op = 3'b010; a = 8'd7; b = 8'd9; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset in_ready", in_ready[1], 1);
        chk("midreset out_valid", out_valid[1], 0);
        chk("midreset op_count", op_count[1], 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("postreset out_valid", out_valid[1], 0);
        end

        // Counter wrap with randomized operations.
        for (int i = 0; i < 256; i++) begin
            run_op(3'($urandom), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                   1'($urandom), ev, l1, l4);
            if (i == 254) begin
                wait_idle();
                chk("op_count 255", op_count[1], 255);
            end
        end
        wait_idle();
        chk("op_count wrap x1", op_count[0], 0);
        chk("op_count wrap x4", op_count[1], 0);

`ifdef ACC_CHAIN_EN
        run_op(3'b000, 8'd10, 8'd5, 1'b0, ev, l1, l4);
        chk("acc add", ev[15:0], 16'h000F);
        run_op(3'b001, 8'd200, 8'd3, 1'b1, ev, l1, l4);
        chk("acc chain sub", ev[15:0], 16'h000C);
`endif

        // Free-running random traffic with random back-pressure and rare resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = 1'($urandom);
            op        = 3'($urandom);
            a         = 8'($urandom);
            b         = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            acc_sel   = 1'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
